// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad front end. Drives one column at a time,
// synchronises and debounces the rows, and emits one load_num strobe with the
// key code per accepted press. A new press is accepted only after release.
module keypad_scanner #(
    parameter int unsigned SCAN_CYCLES     = 27000,
    parameter int unsigned DEBOUNCE_CYCLES = 270000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_i,
    output logic [3:0] col_o,
    output logic [3:0] num,
    output logic       load_num,
    output logic       key_pressed
);

    localparam int unsigned DW = $clog2(SCAN_CYCLES);
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {
        S_SCAN         = 2'd0,
        S_DEBOUNCE     = 2'd1,
        S_EMIT         = 2'd2,
        S_WAIT_RELEASE = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [3:0]    r_sync1;
    logic [3:0]    r_rows_s;
    logic [DW-1:0] r_dwell;
    logic [DW-1:0] w_dwell_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [1:0]    r_col;
    logic [1:0]    w_col_nxt;
    logic [3:0]    r_cap;
    logic [3:0]    w_cap_nxt;
    logic [3:0]    r_num;
    logic [3:0]    w_num_nxt;
    logic [3:0]    r_col_o;
    logic          r_load_num;
    logic          r_key_pressed;
    logic [1:0]    w_row;
    logic [3:0]    w_code;
    logic          w_mapped;

    assign col_o       = r_col_o;
    assign num         = r_num;
    assign load_num    = r_load_num;
    assign key_pressed = r_key_pressed;

    // Two-flop synchroniser for the asynchronous row inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1  <= 4'hF;
            r_rows_s <= 4'hF;
        end else begin
            r_sync1  <= row_i;
            r_rows_s <= r_sync1;
        end
    end

    // Key code of the captured pattern; lowest low row wins, column 3 is unmapped.
    always_comb begin
        w_row    = 2'd3;
        w_code   = 4'h0;
        w_mapped = (r_col != 2'd3);
        if (!r_cap[0]) begin
            w_row = 2'd0;
        end else if (!r_cap[1]) begin
            w_row = 2'd1;
        end else if (!r_cap[2]) begin
            w_row = 2'd2;
        end
        case ({w_row, r_col})
            4'b00_00: w_code = 4'h1;
            4'b00_01: w_code = 4'h2;
            4'b00_10: w_code = 4'h3;
            4'b01_00: w_code = 4'h4;
            4'b01_01: w_code = 4'h5;
            4'b01_10: w_code = 4'h6;
            4'b10_00: w_code = 4'h7;
            4'b10_01: w_code = 4'h8;
            4'b10_10: w_code = 4'h9;
            4'b11_00: w_code = 4'hC;
            4'b11_01: w_code = 4'h0;
            4'b11_10: w_code = 4'hB;
            default:  w_code = 4'h0;
        endcase
    end

    // Next-state logic for scan, debounce, emit and release tracking.
    always_comb begin
        w_state_nxt = r_state;
        w_dwell_nxt = r_dwell;
        w_cnt_nxt   = r_cnt;
        w_col_nxt   = r_col;
        w_cap_nxt   = r_cap;
        w_num_nxt   = r_num;
        case (r_state)
            S_SCAN: begin
                if (r_dwell == DW'(SCAN_CYCLES - 1)) begin
                    w_dwell_nxt = '0;
                    if (r_rows_s == 4'hF) begin
                        w_col_nxt = r_col + 2'd1;
                    end else begin
                        w_cap_nxt   = r_rows_s;
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_DEBOUNCE;
                    end
                end else begin
                    w_dwell_nxt = r_dwell + DW'(1);
                end
            end
            S_DEBOUNCE: begin
                if (r_rows_s != r_cap) begin
                    w_state_nxt = S_SCAN;
                    w_col_nxt   = r_col + 2'd1;
                    w_cnt_nxt   = '0;
                    w_dwell_nxt = '0;
                end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    w_cnt_nxt = '0;
                    if (w_mapped) begin
                        w_state_nxt = S_EMIT;
                        w_num_nxt   = w_code;
                    end else begin
                        w_state_nxt = S_WAIT_RELEASE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_EMIT: begin
                w_state_nxt = S_WAIT_RELEASE;
            end
            S_WAIT_RELEASE: begin
                if (r_rows_s == 4'hF) begin
                    if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                        w_state_nxt = S_SCAN;
                        w_col_nxt   = r_col + 2'd1;
                        w_cnt_nxt   = '0;
                        w_dwell_nxt = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end else begin
                    w_cnt_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = S_SCAN;
            end
        endcase
    end

    // State, counters and registered outputs derived from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_SCAN;
            r_dwell       <= '0;
            r_cnt         <= '0;
            r_col         <= 2'd0;
            r_cap         <= 4'hF;
            r_num         <= 4'h0;
            r_col_o       <= 4'b1110;
            r_load_num    <= 1'b0;
            r_key_pressed <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_dwell       <= w_dwell_nxt;
            r_cnt         <= w_cnt_nxt;
            r_col         <= w_col_nxt;
            r_cap         <= w_cap_nxt;
            r_num         <= w_num_nxt;
            r_col_o       <= ~(4'b0001 << w_col_nxt);
            r_load_num    <= (w_state_nxt == S_EMIT);
            r_key_pressed <= (w_state_nxt != S_SCAN);
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Testbench for keypad_scanner with a behavioural 4x4 key matrix model.
module tb_keypad_scanner;

    localparam int unsigned SCAN_CYCLES     = 4;
    localparam int unsigned DEBOUNCE_CYCLES = 8;

    logic       clk;
    logic       rst;
    logic [3:0] row_i;
    logic [3:0] col_o;
    logic [3:0] num;
    logic       load_num;
    logic       key_pressed;

    logic [15:0] mask;   // bit r*4+c = key at (row r, col c) held down

    int n_err;
    int n_chk;
    int cyc;
    int pulse_cnt;
    int dbl_cnt;
    int rise_cyc;
    int load_cyc;
    logic prev_load;
    logic prev_kp;

    keypad_scanner #(
        .SCAN_CYCLES     (SCAN_CYCLES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .row_i       (row_i),
        .col_o       (col_o),
        .num         (num),
        .load_num    (load_num),
        .key_pressed (key_pressed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Matrix: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        row_i = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (mask[r*4+c] && !col_o[c]) row_i[r] = 1'b0;
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor: counts pulses, flags back-to-back strobes, times latency.
    always @(negedge clk) begin
        if (load_num) begin
            pulse_cnt = pulse_cnt + 1;
            load_cyc  = cyc;
            if (prev_load) dbl_cnt = dbl_cnt + 1;
        end
        if (key_pressed && !prev_kp) rise_cyc = cyc;
        prev_load = load_num;
        prev_kp   = key_pressed;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Release all keys, count edges until key_pressed drops (bounded).
    task automatic release_and_wait(output int k);
        mask = 16'h0;
        k = 0;
        do begin
            step();
            k++;
        end while (key_pressed && k < 100);
    endtask

    typedef struct {
        string       name;
        logic [15:0] keys;
        int          hold;
        int          exp_pulses;
        logic [3:0]  exp_num;
        logic [3:0]  exp_col_after;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int p0;
        int k;

        vecs[0] = '{"key5",  16'h0020, 200, 1, 4'h5, 4'b1011};
        vecs[1] = '{"hash",  16'h4000,  60, 1, 4'hB, 4'b0111};
        vecs[2] = '{"star",  16'h1000,  60, 1, 4'hC, 4'b1101};
        vecs[3] = '{"keyA",  16'h0008, 100, 0, 4'hC, 4'b1110};
        vecs[4] = '{"k1k4",  16'h0011,  60, 1, 4'h1, 4'b1101};

        n_err = 0; n_chk = 0; cyc = 0; pulse_cnt = 0; dbl_cnt = 0;
        rise_cyc = 0; load_cyc = 0; prev_load = 1'b0; prev_kp = 1'b0;
        mask = 16'h0;
        rst  = 1'b1;
        repeat (3) step();
        chk("rst_col", 32'(col_o), 32'(4'b1110));
        chk("rst_num", 32'(num), 0);
        chk("rst_load", 32'(load_num), 0);
        chk("rst_kp", 32'(key_pressed), 0);
        rst = 1'b0;
        repeat (5) step();

        for (int i = 0; i < 5; i++) begin
            p0   = pulse_cnt;
            mask = vecs[i].keys;
            repeat (vecs[i].hold) step();
            chk({vecs[i].name, "_kp_held"}, 32'(key_pressed), 1);
            chk({vecs[i].name, "_pulses"}, pulse_cnt - p0, vecs[i].exp_pulses);
            chk({vecs[i].name, "_num"}, 32'(num), 32'(vecs[i].exp_num));
            if (vecs[i].exp_pulses == 1)
                chk({vecs[i].name, "_latency"}, load_cyc - rise_cyc, DEBOUNCE_CYCLES);
            release_and_wait(k);
            chk({vecs[i].name, "_release_edges"}, k, 10);
            chk({vecs[i].name, "_col_after"}, 32'(col_o), 32'(vecs[i].exp_col_after));
            repeat (20) step();
            chk({vecs[i].name, "_no_extra"}, pulse_cnt - p0, vecs[i].exp_pulses);
            chk({vecs[i].name, "_num_hold"}, 32'(num), 32'(vecs[i].exp_num));
        end

        // Key 7 bouncing, then held stable.
        p0 = pulse_cnt;
        for (int b = 0; b < 10; b++) begin
            mask = 16'h0100;
            repeat (3) step();
            mask = 16'h0000;
            repeat (2) step();
        end
        chk("bounce_pulses", pulse_cnt - p0, 0);
        chk("bounce_num", 32'(num), 32'(4'h1));
        mask = 16'h0100;
        repeat (100) step();
        chk("key7_pulses", pulse_cnt - p0, 1);
        chk("key7_num", 32'(num), 32'(4'h7));
        chk("key7_latency", load_cyc - rise_cyc, DEBOUNCE_CYCLES);
        release_and_wait(k);
        chk("key7_release_kp", 32'(key_pressed), 0);
        repeat (10) step();

        // Reset while key 9 is being debounced.
        p0   = pulse_cnt;
        mask = 16'h0400;
        k    = 0;
        while (!key_pressed && k < 50) begin
            step();
            k++;
        end
        chk("k9_debounce_entered", 32'(key_pressed), 1);
        repeat (2) step();
        rst = 1'b1;
        step();
        chk("midrst_col", 32'(col_o), 32'(4'b1110));
        chk("midrst_kp", 32'(key_pressed), 0);
        chk("midrst_num", 32'(num), 0);
        chk("midrst_load", 32'(load_num), 0);
        rst = 1'b0;
        chk("midrst_pulses", pulse_cnt - p0, 0);
        repeat (100) step();
        chk("k9_pulses", pulse_cnt - p0, 1);
        chk("k9_num", 32'(num), 32'(4'h9));
        release_and_wait(k);
        chk("k9_release_edges", k, 10);

        chk("no_double_strobe", dbl_cnt, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
